// File: rtl/inst_fetch_q_if.sv
// Instruction-side AHB-Lite bus between the fetch unit (master) and memory (slave).
interface inst_fetch_q_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned DATA_W = 64
);
  logic [XLEN-1:0]   HADDR;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;

  modport master (output HADDR, output HTRANS, input HRDATA, input HREADY);
  modport slave  (input HADDR, input HTRANS, output HRDATA, output HREADY);
endinterface

// File: rtl/inst_fetch_q.sv
// Instruction fetch unit: pipelined AHB-Lite fetch into a PC-tagged prefetch queue,
// with decode back-pressure and redirect (flush + kill of the in-flight transfer).
module inst_fetch_q #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     DATA_W     = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  inst_fetch_q_if.master     bus,
  output logic [31:0]        inst,
  output logic [XLEN-1:0]    inst_pc,
  output logic               inst_valid
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  // fetch / bus state
  logic [XLEN-1:0]  fetch_pc;
  logic             run_q;
  logic             wait_q;
  logic [1:0]       htrans_q;
  logic             dp_valid;
  logic             dp_kill;
  logic [XLEN-1:0]  dp_addr;
  logic             redir_pend;
  logic [XLEN-1:0]  redir_pc;

  // prefetch queue
  logic [XLEN-1:0]  q_pc   [FIFO_DEPTH];
  logic [31:0]      q_inst [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // combinational helpers
  logic [CNT_W-1:0] occ_c;
  logic             issue_c;
  logic [1:0]       htrans_c;
  logic             accept_c;
  logic             complete_c;
  logic             redir_now_c;
  logic [XLEN-1:0]  redir_tgt_c;
  logic             flush_c;
  logic             push_c;
  logic             pop_c;
  logic [31:0]      word_c;
  logic             unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Select the 32-bit half of the data beat addressed by the data phase.
  if (DATA_W == 64) begin : g_w64
    assign word_c = dp_addr[2] ? bus.HRDATA[DATA_W-1:32] : bus.HRDATA[31:0];
  end else begin : g_w32
    assign word_c = bus.HRDATA[31:0];
  end

  // Issue/handshake decode; HTRANS is frozen for the whole of a wait state.
  always_comb begin
    occ_c       = count + CNT_W'(dp_valid && !dp_kill);
    issue_c     = run_q && (occ_c < CNT_W'(FIFO_DEPTH)) && !redir_pend;
    htrans_c    = wait_q ? htrans_q : (issue_c ? HT_NONSEQ : HT_IDLE);
    accept_c    = (htrans_c == HT_NONSEQ) && bus.HREADY;
    complete_c  = dp_valid && bus.HREADY;
    redir_now_c = bus.HREADY && (redirect_valid || redir_pend);
    redir_tgt_c = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : redir_pc;
    flush_c     = redirect_valid || redir_now_c;
    push_c      = complete_c && !dp_kill && !redir_now_c;
    pop_c       = inst_valid && !stall && !flush_c;
  end

  assign bus.HADDR  = fetch_pc;
  assign bus.HTRANS = htrans_c;

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

  // Address phase, data phase and redirect bookkeeping.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      run_q      <= 1'b0;
      wait_q     <= 1'b0;
      htrans_q   <= HT_IDLE;
      dp_valid   <= 1'b0;
      dp_kill    <= 1'b0;
      dp_addr    <= '0;
      redir_pend <= 1'b0;
      redir_pc   <= '0;
    end else begin
      run_q    <= 1'b1;
      wait_q   <= !bus.HREADY;
      htrans_q <= htrans_c;

      if (redir_now_c) begin
        redir_pend <= 1'b0;
      end else if (redirect_valid) begin
        redir_pend <= 1'b1;
        redir_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      end

      if (redir_now_c) begin
        fetch_pc <= redir_tgt_c;
      end else if (accept_c) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      // An address taken on the redirect edge is already stale: mark it killed.
      if (accept_c) begin
        dp_valid <= 1'b1;
        dp_kill  <= redir_now_c;
        dp_addr  <= bus.HADDR;
      end else if (complete_c) begin
        dp_valid <= 1'b0;
        dp_kill  <= 1'b0;
      end else if (redirect_valid && dp_valid) begin
        dp_kill  <= 1'b1;
      end
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_c) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Queue storage; contents are only visible through inst_valid.
  always_ff @(posedge CLK) begin
    if (push_c) begin
      q_pc[wr_ptr]   <= dp_addr;
      q_inst[wr_ptr] <= word_c;
    end
  end

endmodule

// File: tb/tb_inst_fetch_q.sv
// Self-checking bench for inst_fetch_q: directed scenarios plus randomized stall/wait/redirect
// traffic, checked against a transaction-level model of the fetch stream and bus.
module tb_inst_fetch_q;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 4;
  localparam logic [63:0] RPC    = 64'h1000;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid;

  inst_fetch_q_if #(.XLEN(XLEN), .DATA_W(DATA_W)) bus ();

  inst_fetch_q #(
    .XLEN(XLEN), .DATA_W(DATA_W), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus(bus),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int          m_out;
  logic        m_pend;
  logic [63:0] m_tgt, exp_addr, exp_pc, s_addr;
  logic        s_pend;
  logic [1:0]  exp_ht;
  logic        w_prev, redir_prev;

  // sampled DUT outputs for the current cycle
  logic [63:0] s_haddr, s_ipc;
  logic [1:0]  s_htrans;
  logic        s_iv;
  logic [31:0] s_inst;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory image: each 32-bit word holds its own byte address.
  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0];
  endfunction

  function automatic logic [63:0] hrd(input logic [63:0] a);
    return {word({a[63:3], 3'b100}), word({a[63:3], 3'b000})};
  endfunction

  task automatic observe();
    s_haddr  = bus.HADDR;
    s_htrans = bus.HTRANS;
    s_iv     = inst_valid;
    s_inst   = inst;
    s_ipc    = inst_pc;
    if (w_prev) exp_ht = (m_out < int'(DEPTH) && !m_pend) ? 2'b10 : 2'b00;
    chk("htrans", 64'(s_htrans), 64'(exp_ht));
    chk("haddr", s_haddr, exp_addr);
    if (redir_prev) chk("flush_valid", 64'(s_iv), 64'd0);
    if (s_iv) begin
      chk("inst_pc", s_ipc, exp_pc);
      chk("inst", 64'(s_inst), 64'(word(exp_pc)));
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, sample the next cycle.
  task automatic tick(input logic hr, input logic st, input logic rv, input logic [63:0] rpc);
    logic [63:0] tgt;
    logic acc, pop;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bus.HREADY     = hr;
    bus.HRDATA     = hrd(s_addr);
    tgt = {rpc[63:2], 2'b00};
    acc = (s_htrans == 2'b10) && hr;
    pop = s_iv && !st && !rv;
    if (hr && (rv || m_pend)) begin
      exp_addr = rv ? tgt : m_tgt;
      m_pend   = 1'b0;
      m_out    = 0;
    end else if (rv) begin
      m_pend = 1'b1;
      m_tgt  = tgt;
      m_out  = 0;
    end else begin
      if (acc) begin exp_addr = exp_addr + 64'd4; m_out++; end
      if (pop) begin exp_pc = exp_pc + 64'd4; m_out--; end
    end
    if (rv) exp_pc = tgt;
    if (acc) begin
      s_addr = s_haddr;
      s_pend = 1'b1;
    end else if (hr) begin
      s_pend = 1'b0;
    end
    w_prev     = hr;
    redir_prev = rv;
    @(negedge CLK);
    observe();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus.HREADY = 1'b1;
    bus.HRDATA = '0;
    #1;
    chk("rst_htrans", 64'(bus.HTRANS), 64'd0);
    chk("rst_haddr", bus.HADDR, RPC);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    m_out = 0; m_pend = 1'b0; m_tgt = '0;
    exp_addr = RPC; exp_pc = RPC; s_addr = '0; s_pend = 1'b0;
    exp_ht = 2'b00; w_prev = 1'b1; redir_prev = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    observe();
  endtask

  logic found;
  logic [63:0] rtgt;

  initial begin
    // basic streaming, latency and half selection
    do_reset();
    chk("t1_haddr0", s_haddr, 64'h1000);
    chk("t1_nonseq0", 64'(s_htrans), 64'd2);
    chk("t1_valid0", 64'(s_iv), 64'd0);
    tick(1, 0, 0, '0);
    chk("t1_haddr1", s_haddr, 64'h1004);
    chk("t1_valid1", 64'(s_iv), 64'd0);
    tick(1, 0, 0, '0);
    chk("t1_haddr2", s_haddr, 64'h1008);
    chk("t1_valid2", 64'(s_iv), 64'd1);
    chk("t1_pc2", s_ipc, 64'h1000);
    chk("t1_inst2", 64'(s_inst), 64'h1000);
    tick(1, 0, 0, '0);
    chk("t1_pc3", s_ipc, 64'h1004);
    chk("t1_inst3", 64'(s_inst), 64'h1004);

    // stall fills the queue, then drains in order
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 1, 0, '0);
    chk("t2_idle", 64'(s_htrans), 64'd0);
    chk("t2_frozen_pc", s_ipc, 64'h1000);
    chk("t2_valid", 64'(s_iv), 64'd1);
    chk("t2_haddr", s_haddr, 64'h1010);
    for (int i = 0; i < 8; i++) tick(1, 0, 0, '0);

    // wait states during the data phase of 0x1008
    do_reset();
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    tick(1, 0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, '0);
      chk("t3_wait_haddr", s_haddr, 64'h100C);
      chk("t3_wait_nonseq", 64'(s_htrans), 64'd2);
    end
    tick(1, 0, 0, '0);

    // redirect while the data phase of 0x1010 is pending
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (s_haddr == 64'h1014 && s_pend) found = 1'b1;
      else tick(1, 0, 0, '0);
    end
    chk("t4_reach_1010", 64'(found), 64'd1);
    tick(1, 0, 1, 64'h2003);
    chk("t4_haddr", s_haddr, 64'h2000);
    chk("t4_nonseq", 64'(s_htrans), 64'd2);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1, 0, 0, '0);
      found = s_iv;
    end
    chk("t4_got_valid", 64'(found), 64'd1);
    chk("t4_first_pc", s_ipc, 64'h2000);

    // two redirects during a wait state: only the last target is fetched
    found = s_pend;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1, 0, 0, '0);
      found = s_pend;
    end
    chk("t5_dp_pending", 64'(found), 64'd1);
    tick(0, 0, 1, 64'h2500);
    tick(0, 0, 1, 64'h3000);
    tick(1, 0, 0, '0);
    chk("t5_haddr", s_haddr, 64'h3000);
    chk("t5_nonseq", 64'(s_htrans), 64'd2);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, '0);

    // address wrap at the top of the address space
    tick(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t6_top", s_haddr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1, 0, 0, '0);
    chk("t6_wrap", s_haddr, 64'h0);
    for (int i = 0; i < 6; i++) tick(1, 0, 0, '0);

    // randomized stall / wait-state / redirect traffic
    for (int i = 0; i < 2500; i++) begin
      logic hr, st, rv;
      hr = s_pend ? ($urandom_range(0, 9) > 2) : 1'b1;
      st = ($urandom_range(0, 9) < 4);
      rv = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 2) == 0) rtgt = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 31));
      else rtgt = {32'h0, $urandom};
      tick(hr, st, rv, rtgt);
    end

    // asynchronous reset in the middle of traffic, then restart
    for (int i = 0; i < 5; i++) tick(1, 0, 0, '0);
    do_reset();
    for (int i = 0; i < 8; i++) tick(1, ($urandom_range(0, 1) == 1), 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

endmodule
